// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: instruction/opcode widths, major opcode constants
// (also used by control_unit) and the opcode-field extractor.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 5;

  // Major opcodes as seen in instr[6:2]
  localparam logic [OP_W-1:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [OP_W-1:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [OP_W-1:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [OP_W-1:0] OPCODE_STORE  = 5'b01000;
  localparam logic [OP_W-1:0] OPCODE_OP     = 5'b01100;
  localparam logic [OP_W-1:0] OPCODE_LUI    = 5'b01101;
  localparam logic [OP_W-1:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [OP_W-1:0] OPCODE_JALR   = 5'b11001;
  localparam logic [OP_W-1:0] OPCODE_JAL    = 5'b11011;
  localparam logic [OP_W-1:0] OPCODE_SYSTEM = 5'b11100;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[6:2];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO with registered head, synchronous flush and occupancy count.
// Ports: clk, rst_n (async active-low), i_push/i_data write side, i_pop read side
// (ignored when empty), i_flush empties the FIFO (wins over push/pop),
// o_data head entry, o_empty, o_count occupancy.
module ifu_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !i_flush && (r_count != '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Upstream credit accounting must never push into a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && w_full));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory under a
// credit limit, buffers in-order responses in a prefetch FIFO, and presents
// {instr, pc, op} to decode via valid/ready. A redirect flushes the FIFO, restarts
// fetch at redirect_pc and discards responses still in flight.
// Ports: clk, rst_n (async active-low); imem_req_* request channel; imem_rsp_* response
// channel (no backpressure); id_* decode channel; redirect_valid/redirect_pc;
// fetch_misaligned only when IFU_MISALIGN_TRAP_EN is defined.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned redirect target traps and
// blocks fetch until an aligned redirect). Undefined: redirect_pc[1:0] is forced to 0.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc,
  output logic [OP_W-1:0]    id_op,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic               fetch_misaligned
`endif
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = INSTR_W + XLEN;

  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    r_rsp_pc;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   r_discard;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_empty;
  logic [ENTRY_W-1:0] w_head;
  logic [XLEN-1:0]    w_target;
  logic [SUM_W-1:0]   w_credit_used;
  logic               w_trap_block;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_misaligned;

  // Sticky trap flag, updated by every redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_misaligned <= 1'b0;
    else if (redirect_valid) r_misaligned <= (redirect_pc[1:0] != 2'b00);
  end

  assign w_target         = redirect_pc;
  assign w_trap_block     = r_misaligned;
  assign fetch_misaligned = r_misaligned;
`else
  assign w_target     = redirect_pc & ~XLEN'(3);
  assign w_trap_block = 1'b0;
`endif

  // Buffered entries plus useful (non-discarded) requests in flight
  assign w_credit_used = SUM_W'(w_fifo_count) + SUM_W'(r_inflight - r_discard);

  // rst_n gate keeps the request low while reset is asserted
  assign imem_req_valid = rst_n && !redirect_valid && !w_trap_block &&
                          (r_inflight < CNT_W'(FIFO_DEPTH)) &&
                          (w_credit_used < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  assign w_issue = imem_req_valid && imem_req_ready;
  assign w_push  = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
  assign w_pop   = id_valid && id_ready && !redirect_valid;

  // PC tracking for the fetch stream and for the response stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_rsp_pc   <= w_target;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push)  r_rsp_pc   <= r_rsp_pc + XLEN'(4);
    end
  end

  // In-flight and discard counters; a redirect marks everything still outstanding stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(imem_rsp_valid);
      if (redirect_valid)
        r_discard <= r_inflight - CNT_W'(imem_rsp_valid);
      else if (imem_rsp_valid && (r_discard != '0))
        r_discard <= r_discard - CNT_W'(1);
    end
  end

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({imem_rsp_data, r_rsp_pc}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign id_valid = !w_fifo_empty;
  assign id_instr = w_head[ENTRY_W-1:XLEN];
  assign id_pc    = w_head[XLEN-1:0];
  assign id_op    = instr_op(id_instr);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with variable latency,
// an epoch-tagged reference of the fetch/decode streams, directed corner sequences and
// an opcode-extraction vector table. IFU_MISALIGN_TRAP_EN selects the trap variant.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [4:0]  id_op;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_op          (id_op),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } pend_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [4:0]  op;
  } op_vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          lat = 1;
  int          last_rdy = -100;
  logic [31:0] exp_fetch = '0;
  logic [31:0] exp_head = '0;
  logic        misal = 1'b0;
  pend_t       pend[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Instruction memory contents: a few fixed opcodes, hashed words elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h300: return 32'h0000_0063;
      32'h304: return 32'h0000_0013;
      32'h308: return 32'h0000_006F;
      32'h30C: return 32'h0000_0037;
      default: return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F0F;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the reference, advance the reference
  task automatic step(input logic rr, input logic idr, input logic redir, input logic [31:0] tgt);
    logic        rsp;
    logic        exp_rv;
    logic        do_pop;
    logic        hs;
    logic [31:0] w;
    logic [31:0] t_al;
    int          fresh;
    int          rdy;
    pend_t       p;

    imem_req_ready = rr;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rsp            = (pend.size() > 0) && (pend[0].rdy <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;

    fresh = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) fresh++;
    exp_rv = !redir && !misal && (pend.size() < int'(DEPTH)) && ((buffered + fresh) < int'(DEPTH));
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid && exp_rv) chk("req_addr", imem_req_addr, exp_fetch);
    chk("id_valid", 32'(id_valid), 32'(buffered > 0));
    if (buffered > 0) begin
      w = mem_word(exp_head);
      chk("id_pc", id_pc, exp_head);
      chk("id_instr", id_instr, w);
      chk("id_op", 32'(id_op), 32'(w[6:2]));
    end
`ifdef IFU_MISALIGN_TRAP_EN
    chk("misaligned", 32'(fetch_misaligned), 32'(misal));
`endif

    hs     = imem_req_valid && rr;
    do_pop = !redir && idr && (buffered > 0);
    if (do_pop) begin
      buffered--;
      exp_head += 32'd4;
    end
    if (rsp) begin
      p = pend.pop_front();
      if (p.epoch == epoch && !redir) buffered++;
    end
    if (hs) begin
      rdy = cyc + lat;
      if (rdy <= last_rdy) rdy = last_rdy + 1;
      last_rdy = rdy;
      pend.push_back('{addr: imem_req_addr, epoch: epoch, rdy: rdy});
      exp_fetch += 32'd4;
    end
    if (redir) begin
      epoch++;
      buffered = 0;
`ifdef IFU_MISALIGN_TRAP_EN
      t_al  = tgt;
      misal = (tgt[1:0] != 2'b00);
`else
      t_al = tgt & ~32'd3;
`endif
      exp_fetch = t_al;
      exp_head  = t_al;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
  endtask

  // Bounded wait for a valid head without consuming it
  task automatic wait_head(input string nm);
    for (int k = 0; k < 40 && !id_valid; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk(nm, 32'(id_valid), 32'd1);
  endtask

  op_vec_t tbl[4];

  initial begin
    logic saw_zero;

    tbl[0] = '{tgt: 32'h300, instr: 32'h0000_0063, op: 5'b11000};
    tbl[1] = '{tgt: 32'h304, instr: 32'h0000_0013, op: 5'b00100};
    tbl[2] = '{tgt: 32'h308, instr: 32'h0000_006F, op: 5'b11011};
    tbl[3] = '{tgt: 32'h30C, instr: 32'h0000_0037, op: 5'b01101};

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(negedge clk);
    #1;

    // Reset state
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_op", 32'(id_op), 32'd0);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
    rst_n = 1'b1;
    #1;

    // Sequential stream with 1-cycle memory; head appears two cycles after first request
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat_early", 32'(id_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat_valid", 32'(id_valid), 32'd1);
    chk("lat_pc", id_pc, 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalled: FIFO fills and requests stop, then resume without loss
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fill_stall", 32'(imem_req_valid), 32'd0);
    chk("fill_head", 32'(id_valid), 32'd1);
    repeat (16) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Three requests in flight when redirected: all three are dropped
    lat = 4;
    step(1'b1, 1'b1, 1'b1, 32'h40);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    lat = 1;
    wait_head("stale_wait");
    chk("stale_pc", id_pc, 32'h100);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a response and a pop
    chk("coinc_pre_valid", 32'(id_valid), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("coinc_flush", 32'(id_valid), 32'd0);
    wait_head("coinc_wait");
    chk("coinc_pc", id_pc, 32'h200);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Opcode extraction vectors
    lat = 2;
    foreach (tbl[i]) begin
      step(1'b1, 1'b0, 1'b1, tbl[i].tgt);
      wait_head("op_wait");
      chk("op_instr", id_instr, tbl[i].instr);
      chk("op_field", 32'(id_op), 32'(tbl[i].op));
    end

    // PC wrap from all-ones-4 to 0
    lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    saw_zero = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (id_valid && id_pc == 32'h0) saw_zero = 1'b1;
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("wrap_zero", 32'(saw_zero), 32'd1);

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned target traps and blocks fetch until an aligned redirect
    step(1'b1, 1'b1, 1'b1, 32'h102);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("trap_flag", 32'(fetch_misaligned), 32'd1);
    chk("trap_noreq", 32'(imem_req_valid), 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("trap_clear", 32'(fetch_misaligned), 32'd0);
    chk("trap_req", 32'(imem_req_valid), 32'd1);
    wait_head("trap_wait");
    chk("trap_pc", id_pc, 32'h200);
`else
    // Low target bits are ignored
    step(1'b1, 1'b1, 1'b1, 32'h102);
    wait_head("align_wait");
    chk("align_pc", id_pc, 32'h100);
`endif
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] t;
      if (n % 100 == 0) lat = $urandom_range(1, 4);
`ifdef IFU_MISALIGN_TRAP_EN
      t = $urandom & 32'h0000_0FFC;
`else
      t = $urandom & 32'h0000_0FFF;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, t);
    end
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset asserted mid-operation returns to the reset state at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_id_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_req_addr", imem_req_addr, 32'h0);
    pend.delete();
    epoch++;
    buffered  = 0;
    exp_fetch = '0;
    exp_head  = '0;
    misal     = 1'b0;
    last_rdy  = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
